// File: rtl/argmax_fix3.sv
// argmax_fix3 -- sequential argmax over NUM_CLASSES signed class scores.
// A start pulse launches a scan that walks out_idx from 0 to NUM_CLASSES-1,
// sampling the upstream score out_val each cycle. The winning index (lowest
// index on ties) is presented on digit with valid held high until the next
// accepted start or reset.
// Optional feature macro: ARGMAX_MARGIN_EN -- when defined, the runner-up score
// is tracked and margin = winner - runner-up; when undefined, margin is 0.
//
// Handshake: start is a single-cycle request honoured only in IDLE or DONE
// (ignored while busy); valid is a level that stays high for as long as the
// result on digit/margin is complete and stable.
module argmax_fix3 #(
    parameter int DATA_WIDTH  = 3,
    parameter int NUM_CLASSES = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [3:0]                   out_idx,
    input  logic signed [DATA_WIDTH-1:0] out_val,
    output logic                         busy,
    output logic                         valid,
    output logic [3:0]                   digit,
    output logic [DATA_WIDTH:0]          margin,
    output logic [1:0]                   dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Seed for max/second: no score can be below this, so the first sample wins.
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    state_t                        state_q, state_d;
    logic [3:0]                    idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]  max_q, max_d;
    logic [3:0]                    digit_q, digit_d;
`ifdef ARGMAX_MARGIN_EN
    logic signed [DATA_WIDTH-1:0]  second_q, second_d;
    logic [DATA_WIDTH:0]           diff;
`endif

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            max_q    <= MOST_NEG;
            digit_q  <= 4'd0;
`ifdef ARGMAX_MARGIN_EN
            second_q <= MOST_NEG;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            max_q    <= max_d;
            digit_q  <= digit_d;
`ifdef ARGMAX_MARGIN_EN
            second_q <= second_d;
`endif
        end
    end

    // Next-state and running top-score update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        max_d    = max_q;
        digit_d  = digit_q;
`ifdef ARGMAX_MARGIN_EN
        second_d = second_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = SCAN;
                    idx_d    = 4'd0;
                    max_d    = MOST_NEG;
                    digit_d  = 4'd0;
`ifdef ARGMAX_MARGIN_EN
                    second_d = MOST_NEG;
`endif
                end
            end
            SCAN: begin
                // Strict compare keeps the lowest index on ties; an equal score
                // drops to the runner-up slot, which gives a zero margin.
                if (out_val > max_q) begin
`ifdef ARGMAX_MARGIN_EN
                    second_d = max_q;
`endif
                    max_d    = out_val;
                    digit_d  = idx_q;
                end
`ifdef ARGMAX_MARGIN_EN
                else if (out_val > second_q) begin
                    second_d = out_val;
                end
`endif
                // idx wraps back to 0 on the last sample so it never leaves range.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = 4'd0;
                end else begin
                    idx_d   = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARGMAX_MARGIN_EN
    // One extra bit of width holds the full winner-minus-runner-up range.
    always_comb begin
        diff = {max_q[DATA_WIDTH-1], max_q} - {second_q[DATA_WIDTH-1], second_q};
    end
    assign margin = (state_q == DONE) ? diff : '0;
`else
    assign margin = '0;
`endif

    assign out_idx     = (state_q == SCAN) ? idx_q : 4'd0;
    assign busy        = (state_q == SCAN);
    assign valid       = (state_q == DONE);
    assign digit       = digit_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_argmax_fix3.sv
// tb_argmax_fix3 -- scoreboard bench for argmax_fix3.
// The upstream score table is modelled as an array indexed by out_idx.
module tb_argmax_fix3;

    localparam int W  = 3;
    localparam int N  = 10;
    localparam int RW = 4 + W + 1;

    // ---------------- clock / reset ----------------
    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [3:0]           out_idx;
    logic signed [W-1:0]  out_val;
    logic                 busy;
    logic                 valid;
    logic [3:0]           digit;
    logic [W:0]           margin;
    logic [1:0]           dbg_state;

    always #5 clk = ~clk;

    logic signed [W-1:0] scores [16];
    assign out_val = scores[out_idx];

    argmax_fix3 #(.DATA_WIDTH(W), .NUM_CLASSES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .out_idx     (out_idx),
        .out_val     (out_val),
        .busy        (busy),
        .valid       (valid),
        .digit       (digit),
        .margin      (margin),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [RW-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: first index holding the maximum, runner-up is the best score
    // among all other indices.
    function automatic logic [RW-1:0] model_result();
        int best;
        int ru;
        int mg;
        logic [W:0] m;
        best = 0;
        for (int i = 1; i < N; i++)
            if (int'(scores[i]) > int'(scores[best])) best = i;
        ru = -(1 << (W - 1));
        for (int j = 0; j < N; j++)
            if (j != best && int'(scores[j]) > ru) ru = int'(scores[j]);
`ifdef ARGMAX_MARGIN_EN
        mg = int'(scores[best]) - ru;
`else
        mg = 0;
`endif
        m = mg[W:0];
        return {best[3:0], m};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_scores(input int v [N]);
        for (int i = 0; i < N; i++) scores[i] = v[i][W-1:0];
    endtask

    task automatic random_scores();
        for (int i = 0; i < N; i++) scores[i] = 3'($urandom_range(0, 7));
    endtask

    task automatic apply_start();
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(model_result());
        @(negedge clk);
        start = 1'b0;
        check_val("valid_drop", valid, 0);
        check_val("busy_up", busy, 1);
    endtask

    // Walks the scan one cycle at a time, optionally re-pulsing start, then
    // pops the expected result once valid appears.
    task automatic run_scan(input string tag, input int repulse_at);
        int n;
        logic [RW-1:0] e;
        for (n = 0; n < 3 * N; n++) begin
            if (valid) break;
            check_val({tag, "_out_idx"}, out_idx, n);
            check_val({tag, "_busy"}, busy, 1);
            if (n == repulse_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        check_val({tag, "_latency"}, n, N);
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_digit"}, digit, e[RW-1 -: 4]);
            check_val({tag, "_margin"}, margin, e[W:0]);
            check_val({tag, "_busy_done"}, busy, 0);
            check_val({tag, "_out_idx_done"}, out_idx, 0);
            repeat (3) @(negedge clk);
            check_val({tag, "_hold_valid"}, valid, 1);
            check_val({tag, "_hold_digit"}, digit, e[RW-1 -: 4]);
            check_val({tag, "_hold_margin"}, margin, e[W:0]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v [N];
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) scores[i] = '0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_valid", valid, 0);
        check_val("rst_digit", digit, 0);
        check_val("rst_margin", margin, 0);
        check_val("rst_out_idx", out_idx, 0);
        check_val("rst_state", dbg_state, 0);

        // start while rst is still high at the edge must be ignored
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_val("start_in_rst", busy, 0);

        // basic pattern
        v = '{0, 1, -2, 3, 0, 0, 0, 0, 0, -4};
        set_scores(v);
        apply_start();
        run_scan("basic", -1);

        // all ties
        v = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        set_scores(v);
        apply_start();
        run_scan("ties", -1);

        // winner at the last index, full margin
        v = '{-4, -4, -4, -4, -4, -4, -4, -4, -4, 3};
        set_scores(v);
        apply_start();
        run_scan("last_idx", -1);

        // start re-pulsed during scan
        v = '{0, 1, -2, 3, 0, 0, 0, 0, 0, -4};
        set_scores(v);
        apply_start();
        run_scan("repulse", 3);

        // reset in the middle of a scan
        apply_start();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_valid", valid, 0);
        check_val("midrst_digit", digit, 0);
        check_val("midrst_margin", margin, 0);
        check_val("midrst_out_idx", out_idx, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("post_rst_idle", busy, 0);
        check_val("post_rst_novalid", valid, 0);
        v = '{1, -1, 0, 2, -3, 3, 3, -4, 0, 1};
        set_scores(v);
        apply_start();
        run_scan("after_rst", -1);

        // start in DONE (valid currently high)
        v = '{-1, -2, -3, 1, 0, -4, 2, 0, 0, 1};
        set_scores(v);
        apply_start();
        run_scan("restart_done", -1);

        // random score tables
        for (int k = 0; k < 6; k++) begin
            random_scores();
            apply_start();
            run_scan("random", -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/argmax_fix3.md
ARGMAX_FIX3 -- requirements
Module: argmax_fix3

Interface
REQ-001 Parameter DATA_WIDTH, default 3, gives the signed width of each class score.
REQ-002 Parameter NUM_CLASSES, default 10, gives the number of class scores scanned.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to classify (driven from upstream done).
REQ-006 out_idx  output  4  class index presented to the upstream output selector.
REQ-007 out_val  input  DATA_WIDTH signed  score for out_idx, combinationally valid in the same cycle.
REQ-008 busy  output  1  high while scanning.
REQ-009 valid  output  1  high while digit/margin hold a completed result.
REQ-010 digit  output  4  index of the winning class.
REQ-011 margin  output  DATA_WIDTH+1 unsigned  winning score minus runner-up score.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL enter SCAN and load idx=0, max=most-negative, second=most-negative, digit=0; valid SHALL drop on that edge.
REQ-014 In SCAN, out_idx SHALL equal idx, busy SHALL be 1, and each edge SHALL sample out_val and increment idx.
REQ-015 Max update: out_val > max (strict, signed) SHALL move max to second, load max=out_val, digit=idx.
REQ-016 Otherwise, out_val > second SHALL load second=out_val.
REQ-017 Ties SHALL keep the lowest index as the winner and give margin 0.
REQ-018 The edge sampling idx=NUM_CLASSES-1 SHALL enter DONE; valid SHALL be 1 and busy 0 from that edge.
REQ-019 Latency: valid SHALL rise exactly NUM_CLASSES edges after the edge that accepted start.
REQ-020 start during SCAN SHALL be ignored; the scan SHALL not restart.
REQ-021 DONE SHALL hold digit, margin and valid until the next accepted start or rst.
REQ-022 out_idx SHALL be 0 in IDLE and DONE.
REQ-023 idx SHALL never exceed NUM_CLASSES-1, and out_idx SHALL never present an out-of-range value.
REQ-024 Margin arithmetic SHALL use a DATA_WIDTH+1-bit signed difference, giving range 0 to 2^DATA_WIDTH-1 (0..7 at default).

Reset
REQ-025 rst=1 SHALL force state=IDLE, idx=0, out_idx=0, busy=0, valid=0, digit=0, margin=0 asynchronously, with no clock required.
REQ-026 rst asserted mid-SCAN SHALL abort the scan with no result; after rst releases, the block SHALL wait in IDLE for a new start.
REQ-027 start coincident with the rst-release edge SHALL be ignored only if rst is still high at that edge.

Configuration
REQ-028 Macro ARGMAX_MARGIN_EN SHALL control margin computation.
REQ-029 With ARGMAX_MARGIN_EN defined, second-max tracking SHALL be built and margin SHALL be valid in DONE.
REQ-030 Without ARGMAX_MARGIN_EN, no second-max register SHALL exist and margin SHALL be tied to 0; all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset then scores {0,1,-2,3,0,0,0,0,0,-4}, start pulse -> out_idx steps 0..9, valid after 10 edges, digit=3, margin=2 (0 with macro off).
REQ-032 All scores equal 2 -> digit=0, margin=0.
REQ-033 Scores {-4,...,-4,3} (3 at index 9) -> digit=9, margin=7; checks boundary index and full margin range.
REQ-034 start re-pulsed on the 4th SCAN cycle -> ignored, and the result is identical to REQ-031.
REQ-035 rst asserted on the 5th SCAN cycle -> outputs go to 0 immediately; a later start yields a correct fresh result.
REQ-036 start pulsed in DONE -> valid drops on the next edge and a new result appears 10 edges later.
